// File: rtl/ysyx_22050612_mem_arbiter.sv
// Memory port arbiter between IFU and LSU: one transaction in flight at a time.
// Optional `ARB_ROUND_ROBIN_EN replaces fixed LSU priority with round robin.
module ysyx_22050612_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  output logic        if_rsp_valid,
  output logic [63:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_wen,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_rsp_valid,
  output logic [63:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RSP
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q;
  logic        wen_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic [15:0] cnt_q;
  logic        err_q;
  logic [63:0] if_rdata_q;
  logic [63:0] ls_rdata_q;
  logic        grant_ls;
  logic        grant_if;
  logic        idle;
  logic        fire;
  logic        timeout;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  // last_q: 0 = IFU granted last, 1 = LSU granted last
  always_comb begin
    grant_ls = ls_req_valid;
    if (ls_req_valid && if_req_valid)
      grant_ls = ~last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b0;
    else if (fire) last_q <= grant_ls;
  end
`else
  assign grant_ls = ls_req_valid;
`endif

  assign grant_if = if_req_valid && !grant_ls;
  assign idle     = (state_q == IDLE) && rst_n;

  assign ls_req_ready = idle && grant_ls;
  assign if_req_ready = idle && grant_if;
  assign fire         = ls_req_ready || if_req_ready;

  assign timeout = cnt_q == 16'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fire) state_d = REQ;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid || timeout) state_d = RSP;
      RSP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        owner_q <= grant_ls;
        wen_q   <= grant_ls && ls_wen;
        addr_q  <= grant_ls ? ls_addr : if_addr;
        wdata_q <= grant_ls ? ls_wdata : 64'h0;
        wmask_q <= (grant_ls && ls_wen) ? ls_wmask : 8'h00;
      end
      if (state_q == REQ && mem_req_ready)
        cnt_q <= '0;
      else if (state_q == WAIT)
        cnt_q <= cnt_q + 16'd1;
      if (state_q == WAIT) begin
        if (mem_rsp_valid) begin
          err_q <= 1'b0;
          if (owner_q) ls_rdata_q <= mem_rdata;
          else         if_rdata_q <= mem_rdata;
        end else if (timeout) begin
          err_q <= 1'b1;
          if (owner_q) ls_rdata_q <= '0;
          else         if_rdata_q <= '0;
        end
      end
    end
  end

  assign mem_req_valid = state_q == REQ;
  assign mem_wen       = wen_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  assign if_rsp_valid = (state_q == RSP) && !owner_q;
  assign ls_rsp_valid = (state_q == RSP) && owner_q;
  assign if_err       = if_rsp_valid && err_q;
  assign ls_err       = ls_rsp_valid && err_q;
  assign if_rdata     = if_rdata_q;
  assign ls_rdata     = ls_rdata_q;

endmodule
